// File: rtl/solver_sequencer_pkg.sv
// Shared definitions for the solver sequencer: FSM state encoding, slot count,
// default widths and a small helper for sizing the solve timer.
package solver_sequencer_pkg;

    localparam int NSAT        = 4;
    localparam int DEF_W       = 32;
    localparam int DEF_IDW     = 6;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SOLVE   = 2'd1,
        ST_HOLD    = 2'd2
    } seq_state_e;

    // Width of a counter that has to reach count-1; never below one bit.
    function automatic int timer_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/solver_sequencer_if.sv
// Bundle of the measurement stream, solver operand/result buses and the fix
// result port. The sequencer sits on the slave side; the surrounding system
// (capture stage, linear_solver, navigation output) is the master.
interface solver_sequencer_if
    import solver_sequencer_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int IDW = DEF_IDW
) ();

    logic                meas_valid;
    logic                meas_ready;
    logic [IDW-1:0]      meas_id;
    logic [W-1:0]        meas_x;
    logic [W-1:0]        meas_y;
    logic [W-1:0]        meas_z;
    logic [W-1:0]        meas_r;
    logic                flush;
    logic                solver_en;
    logic [NSAT*W-1:0]   sol_x;
    logic [NSAT*W-1:0]   sol_y;
    logic [NSAT*W-1:0]   sol_z;
    logic [NSAT*W-1:0]   sol_r;
    logic                solver_done;
    logic [3*W-1:0]      sol_c;
    logic                fix_valid;
    logic                fix_ready;
    logic [3*W-1:0]      fix_c;
    logic                fix_err;
    logic                busy;
    logic [2:0]          slot_cnt;

    modport slave (
        input  meas_valid, meas_id, meas_x, meas_y, meas_z, meas_r, flush,
               solver_done, sol_c, fix_ready,
        output meas_ready, solver_en, sol_x, sol_y, sol_z, sol_r,
               fix_valid, fix_c, fix_err, busy, slot_cnt
    );

    modport master (
        output meas_valid, meas_id, meas_x, meas_y, meas_z, meas_r, flush,
               solver_done, sol_c, fix_ready,
        input  meas_ready, solver_en, sol_x, sol_y, sol_z, sol_r,
               fix_valid, fix_c, fix_err, busy, slot_cnt
    );

endinterface

// File: rtl/solver_sequencer_slot_bank.sv
// Four-entry measurement register file. A write whose ID matches an occupied
// slot overwrites that slot; otherwise it lands in the next free slot. Slots
// fill in order and are only ever cleared all together, so the occupancy count
// doubles as the next free index.
module solver_sequencer_slot_bank
    import solver_sequencer_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int IDW = DEF_IDW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDW-1:0]    wr_id,
    input  logic [W-1:0]      wr_x,
    input  logic [W-1:0]      wr_y,
    input  logic [W-1:0]      wr_z,
    input  logic [W-1:0]      wr_r,
    output logic [2:0]        cnt,
    output logic              fill,
    output logic [NSAT*W-1:0] sol_x,
    output logic [NSAT*W-1:0] sol_y,
    output logic [NSAT*W-1:0] sol_z,
    output logic [NSAT*W-1:0] sol_r
);

    logic [NSAT-1:0] hit;
    logic            any_hit;
    logic [2:0]      cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NSAT; gi++) begin : g_slot
            logic           valid_reg;
            logic [IDW-1:0] id_reg;
            logic [W-1:0]   x_reg;
            logic [W-1:0]   y_reg;
            logic [W-1:0]   z_reg;
            logic [W-1:0]   r_reg;
            logic           wr_sel;

            assign hit[gi] = valid_reg && (id_reg == wr_id);
            assign wr_sel  = wr_en && (any_hit ? hit[gi] : (cnt_reg == 3'(gi)));

            // Slot storage: cleared as a whole, written on a match or as the next free slot.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    valid_reg <= 1'b0;
                    id_reg    <= '0;
                    x_reg     <= '0;
                    y_reg     <= '0;
                    z_reg     <= '0;
                    r_reg     <= '0;
                end else if (wr_sel) begin
                    valid_reg <= 1'b1;
                    id_reg    <= wr_id;
                    x_reg     <= wr_x;
                    y_reg     <= wr_y;
                    z_reg     <= wr_z;
                    r_reg     <= wr_r;
                end
            end

            assign sol_x[gi*W +: W] = x_reg;
            assign sol_y[gi*W +: W] = y_reg;
            assign sol_z[gi*W +: W] = z_reg;
            assign sol_r[gi*W +: W] = r_reg;
        end
    endgenerate

    assign any_hit = |hit;
    // Set on the write that occupies the last free slot.
    assign fill    = wr_en && !any_hit && (cnt_reg == 3'(NSAT - 1));
    assign cnt     = cnt_reg;

    // Occupancy grows only when a new ID is stored.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (wr_en && !any_hit && (cnt_reg != 3'(NSAT))) begin
            cnt_reg <= cnt_reg + 3'd1;
        end
    end

endmodule

// File: rtl/solver_sequencer.sv
// Front-end controller for linear_solver: gathers four satellite measurements,
// runs one bounded solve and hands back the result (or a timeout error) on a
// valid/ready port. The FSM and solve timer live here; storage is in the slot bank.
module solver_sequencer
    import solver_sequencer_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int IDW     = DEF_IDW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    solver_sequencer_if.slave bus
);

    localparam int            TW         = timer_width(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    seq_state_e     state_reg, state_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [3*W-1:0] fix_c_reg, fix_c_next;
    logic           fix_err_reg, fix_err_next;

    logic       bank_wr;
    logic       bank_clr;
    logic       bank_fill;
    logic [2:0] bank_cnt;
    logic       timed_out;

    // A flush in the same cycle drops the measurement, though the handshake still completes.
    assign bank_wr   = (state_reg == ST_COLLECT) && bus.meas_valid && !bus.flush;
    assign timed_out = (timer_reg == TIMER_LAST);

    solver_sequencer_slot_bank #(
        .W   (W),
        .IDW (IDW)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .clr   (bank_clr),
        .wr_en (bank_wr),
        .wr_id (bus.meas_id),
        .wr_x  (bus.meas_x),
        .wr_y  (bus.meas_y),
        .wr_z  (bus.meas_z),
        .wr_r  (bus.meas_r),
        .cnt   (bank_cnt),
        .fill  (bank_fill),
        .sol_x (bus.sol_x),
        .sol_y (bus.sol_y),
        .sol_z (bus.sol_z),
        .sol_r (bus.sol_r)
    );

    // State register together with the solve timer and captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_COLLECT;
            timer_reg   <= '0;
            fix_c_reg   <= '0;
            fix_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            fix_c_reg   <= fix_c_next;
            fix_err_reg <= fix_err_next;
        end
    end

    // Next state; in SOLVE a flush outranks done, and done outranks the timeout.
    always_comb begin
        state_next   = state_reg;
        timer_next   = '0;
        fix_c_next   = fix_c_reg;
        fix_err_next = fix_err_reg;
        case (state_reg)
            ST_COLLECT: begin
                if (bank_fill) begin
                    state_next = ST_SOLVE;
                end
            end
            ST_SOLVE: begin
                if (bus.flush) begin
                    state_next = ST_COLLECT;
                end else if (bus.solver_done) begin
                    state_next   = ST_HOLD;
                    fix_c_next   = bus.sol_c;
                    fix_err_next = 1'b0;
                end else if (timed_out) begin
                    state_next   = ST_HOLD;
                    fix_c_next   = '0;
                    fix_err_next = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.fix_ready) begin
                    state_next = ST_COLLECT;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // State-decoded outputs and the slot-clear strobe.
    always_comb begin
        bus.meas_ready = 1'b0;
        bus.solver_en  = 1'b0;
        bus.fix_valid  = 1'b0;
        bus.busy       = 1'b1;
        bank_clr       = 1'b0;
        case (state_reg)
            ST_COLLECT: begin
                bus.meas_ready = 1'b1;
                bus.busy       = 1'b0;
                bank_clr       = bus.flush;
            end
            ST_SOLVE: begin
                bus.solver_en = 1'b1;
                bank_clr      = bus.flush;
            end
            ST_HOLD: begin
                bus.fix_valid = 1'b1;
                bank_clr      = bus.fix_ready;
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

    assign bus.fix_c    = fix_c_reg;
    assign bus.fix_err  = fix_err_reg;
    assign bus.slot_cnt = bank_cnt;

endmodule

// File: tb/tb_solver_sequencer.sv
// Bench for solver_sequencer: directed scenarios followed by random traffic, with
// every cycle compared against a transaction-level model (a queue of stored
// measurements, a phase and a solve-cycle count).
module tb_solver_sequencer;

    localparam int W       = 32;
    localparam int IDW     = 6;
    localparam int TIMEOUT = 64;
    localparam int NS      = 4;

    localparam int PH_COLLECT = 0;
    localparam int PH_SOLVE   = 1;
    localparam int PH_HOLD    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    solver_sequencer_if #(.W(W), .IDW(IDW)) bus ();

    solver_sequencer #(.W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [W-1:0]   z;
        logic [W-1:0]   r;
    } meas_t;

    meas_t          m_slots[$];
    int             m_phase;
    int             m_cycles;
    logic [3*W-1:0] m_fix_c;
    logic           m_fix_err;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [NS*W-1:0] got, input logic [NS*W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NS*W-1:0] ex, ey, ez, er;
        ex = '0; ey = '0; ez = '0; er = '0;
        foreach (m_slots[i]) begin
            ex[i*W +: W] = m_slots[i].x;
            ey[i*W +: W] = m_slots[i].y;
            ez[i*W +: W] = m_slots[i].z;
            er[i*W +: W] = m_slots[i].r;
        end
        check("meas_ready", bus.meas_ready, m_phase == PH_COLLECT);
        check("solver_en",  bus.solver_en,  m_phase == PH_SOLVE);
        check("fix_valid",  bus.fix_valid,  m_phase == PH_HOLD);
        check("busy",       bus.busy,       m_phase != PH_COLLECT);
        check("slot_cnt",   bus.slot_cnt,   m_slots.size());
        check("sol_x",      bus.sol_x,      ex);
        check("sol_y",      bus.sol_y,      ey);
        check("sol_z",      bus.sol_z,      ez);
        check("sol_r",      bus.sol_r,      er);
        check("fix_c",      bus.fix_c,      m_fix_c);
        check("fix_err",    bus.fix_err,    m_fix_err);
    endtask

    // Apply one cycle of inputs, advance the model, then compare on the falling edge.
    task automatic step(input bit r, input bit v, input logic [IDW-1:0] id, input logic [W-1:0] d,
                        input bit fl, input bit dn, input logic [3*W-1:0] c, input bit fr);
        meas_t m;
        int    k;
        m.id = id;
        m.x  = d;
        m.y  = d ^ 32'h5a5a_5a5a;
        m.z  = ~d;
        m.r  = d + 32'd7;
        rst             = r;
        bus.meas_valid  = v;
        bus.meas_id     = m.id;
        bus.meas_x      = m.x;
        bus.meas_y      = m.y;
        bus.meas_z      = m.z;
        bus.meas_r      = m.r;
        bus.flush       = fl;
        bus.solver_done = dn;
        bus.sol_c       = c;
        bus.fix_ready   = fr;

        if (r) begin
            m_slots.delete();
            m_phase   = PH_COLLECT;
            m_cycles  = 0;
            m_fix_c   = '0;
            m_fix_err = 1'b0;
        end else if (m_phase == PH_COLLECT) begin
            if (fl) begin
                m_slots.delete();
                if (v) $display("meas  id=%0d dropped by flush", id);
            end else if (v) begin
                k = -1;
                foreach (m_slots[i]) if (m_slots[i].id == id) k = i;
                if (k >= 0) m_slots[k] = m;
                else        m_slots.push_back(m);
                $display("meas  id=%0d x=%0d stored=%0d", id, d, m_slots.size());
                if (m_slots.size() == NS) begin
                    m_phase  = PH_SOLVE;
                    m_cycles = 0;
                end
            end
        end else if (m_phase == PH_SOLVE) begin
            if (fl) begin
                m_slots.delete();
                m_phase = PH_COLLECT;
            end else if (dn) begin
                m_fix_c   = c;
                m_fix_err = 1'b0;
                m_phase   = PH_HOLD;
            end else if (m_cycles == TIMEOUT - 1) begin
                m_fix_c   = '0;
                m_fix_err = 1'b1;
                m_phase   = PH_HOLD;
            end else begin
                m_cycles++;
            end
        end else begin
            if (fr) begin
                $display("fix   c=%h err=%0d", m_fix_c, m_fix_err);
                m_slots.delete();
                m_phase = PH_COLLECT;
            end
        end

        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic fill4(input int base_id, input logic [W-1:0] base_d);
        for (int i = 0; i < NS; i++) step(0, 1, IDW'(base_id + i), base_d + W'(i * 1000), 0, 0, '0, 0);
    endtask

    int n_en;
    logic [W-1:0] tvec[NS];

    initial begin
        tvec[0] = 32'd2088202;
        tvec[1] = 32'd11092568;
        tvec[2] = 32'd35606984;
        tvec[3] = 32'd3966929;

        // Reset.
        step(1, 0, '0, '0, 0, 0, '0, 0);
        step(1, 0, '0, '0, 0, 0, '0, 0);
        check("rst_meas_ready", bus.meas_ready, 1);
        idle(2);

        // Four distinct satellites; solver_en one cycle after the fourth accept.
        for (int i = 0; i < NS; i++) step(0, 1, IDW'(i + 1), tvec[i], 0, 0, '0, 0);
        check("t1_solver_en", bus.solver_en, 1);
        check("t1_sol_x", bus.sol_x, {tvec[3], tvec[2], tvec[1], tvec[0]});

        // Done ten cycles into SOLVE, then a stalled consumer.
        idle(9);
        step(0, 0, '0, '0, 0, 1, {32'd30, 32'd20, 32'd10}, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, '0, 0, 0, '0, 0);
            check("t2_fix_c", bus.fix_c, {32'd30, 32'd20, 32'd10});
        end
        step(0, 0, '0, '0, 0, 0, '0, 1);

        // Duplicate ID overwrites its slot.
        step(0, 1, 6'd5, 32'd111, 0, 0, '0, 0);
        step(0, 1, 6'd5, 32'd222, 0, 0, '0, 0);
        step(0, 1, 6'd6, 32'd333, 0, 0, '0, 0);
        step(0, 1, 6'd7, 32'd444, 0, 0, '0, 0);
        check("t3_not_yet", bus.solver_en, 0);
        step(0, 1, 6'd8, 32'd555, 0, 0, '0, 0);
        check("t3_slot0_x", bus.sol_x[W-1:0], 32'd222);
        idle(3);
        step(0, 0, '0, '0, 0, 1, {32'd3, 32'd2, 32'd1}, 1);
        step(0, 0, '0, '0, 0, 0, '0, 1);

        // Timeout: solver_en high exactly TIMEOUT cycles.
        fill4(9, 32'd900);
        n_en = bus.solver_en ? 1 : 0;
        for (int i = 0; i < TIMEOUT + 6; i++) begin
            step(0, 0, '0, '0, 0, 0, '0, 0);
            if (bus.solver_en) n_en++;
        end
        check("t4_en_cycles", n_en, TIMEOUT);
        check("t4_fix_err", bus.fix_err, 1);
        step(0, 0, '0, '0, 0, 0, '0, 1);

        // Flush during collection and during a solve.
        step(0, 1, 6'd20, 32'd1, 0, 0, '0, 0);
        step(0, 1, 6'd21, 32'd2, 0, 0, '0, 0);
        step(0, 1, 6'd22, 32'd3, 1, 0, '0, 0);
        check("t5_cnt_after_flush", bus.slot_cnt, 0);
        fill4(30, 32'd3000);
        idle(4);
        step(0, 0, '0, '0, 1, 0, '0, 0);
        check("t5_en_after_flush", bus.solver_en, 0);
        for (int i = 0; i < 8; i++) step(0, 0, '0, '0, 0, 0, '0, 1);

        // Done on the timeout cycle wins.
        fill4(40, 32'd4000);
        idle(TIMEOUT - 1);
        step(0, 0, '0, '0, 0, 1, {32'd9, 32'd8, 32'd7}, 0);
        check("t6_done_wins_err", bus.fix_err, 0);
        step(0, 0, '0, '0, 0, 0, '0, 1);

        // Reset mid-solve, late done ignored.
        fill4(50, 32'd5000);
        idle(4);
        step(1, 0, '0, '0, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0, 1, {32'd6, 32'd5, 32'd4}, 0);
        check("t6_no_fix_after_rst", bus.fix_valid, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) == 0,
                 $urandom_range(1),
                 IDW'($urandom_range(7)),
                 W'($urandom),
                 $urandom_range(29) == 0,
                 $urandom_range(19) == 0,
                 {W'($urandom), W'($urandom), W'($urandom)},
                 $urandom_range(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
